// File: rtl/rf_dump_reader.sv
// Sequential register-file dump client: walks read addresses 0..NUM_REGS-1 and
// streams each captured word out as an (addr, data) beat over valid/ready.
module rf_dump_reader #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] rf_read_addr_o,
   input  logic [DATA_W-1:0] rf_read_data_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic [DATA_W-1:0] dump_data_o
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      SEND,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      addr_d         = addr_q;
      data_d         = data_q;
      valid_d        = valid_q;
      rf_read_addr_o = idx_q;
      case (state_q)
         IDLE: begin
            rf_read_addr_o = '0;
            if (start_i) begin
               idx_d   = '0;
               state_d = READ;
            end
         end
         // The read port is asynchronous, so the word is captured in the same cycle the address is driven.
         READ: begin
            data_d  = rf_read_data_i;
            addr_d  = idx_q;
            valid_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (valid_q && dump_ready_i) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = READ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign dump_valid_o = valid_q;
   assign dump_addr_o  = addr_q;
   assign dump_data_o  = data_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench: behavioural 32x32 register file with two async read ports
// feeding a 32-register dump reader and a 16-register dump reader.
module tb_rf_dump_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] rf [32];

   logic        startA, busyA, doneA, validA, readyA;
   logic [4:0]  raddrA, addrA;
   logic [31:0] rdA, dataA;
   logic        startB, busyB, doneB, validB, readyB;
   logic [4:0]  raddrB, addrB;
   logic [31:0] rdB, dataB;

   logic [31:0] exp_beat [32];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we && waddr != 5'd0) rf[waddr] <= wdata;
   end
   assign rdA = (raddrA == 5'd0) ? 32'd0 : rf[raddrA];
   assign rdB = (raddrB == 5'd0) ? 32'd0 : rf[raddrB];

   rf_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dutA (
      .clk_i(clk), .rst_i(rst), .start_i(startA), .busy_o(busyA), .done_o(doneA),
      .rf_read_addr_o(raddrA), .rf_read_data_i(rdA), .dump_valid_o(validA),
      .dump_ready_i(readyA), .dump_addr_o(addrA), .dump_data_o(dataA)
   );

   rf_dump_reader #(.NUM_REGS(16), .ADDR_W(5), .DATA_W(32)) dutB (
      .clk_i(clk), .rst_i(rst), .start_i(startB), .busy_o(busyB), .done_o(doneB),
      .rf_read_addr_o(raddrB), .rf_read_data_i(rdB), .dump_valid_o(validB),
      .dump_ready_i(readyB), .dump_addr_o(addrB), .dump_data_o(dataB)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full dump on instance A; optional random stalls, start pokes, and mid-dump writes.
   task automatic do_dump(input int stall_pct, input bit poke, input bit mode5);
      int          cyc, beat, dones, stall3;
      bit          rdy, prev_stall;
      logic [4:0]  pa;
      logic [31:0] pd;
      cyc = 0; beat = 0; dones = 0; stall3 = 0; prev_stall = 1'b0; pa = '0; pd = '0;
      startA = 1'b1;
      step();
      startA = 1'b0;
      chk("busy_after_start", {31'd0, busyA}, 32'd1);
      forever begin
         rdy = ($urandom_range(99) >= stall_pct);
         if (validA) begin
            if (prev_stall) begin
               chk("stall_addr_stable", {27'd0, addrA}, {27'd0, pa});
               chk("stall_data_stable", dataA, pd);
            end
            if (mode5 && addrA == 5'd3 && stall3 < 3) begin
               rdy = 1'b0;
               stall3++;
               if (stall3 == 1) begin we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; end
            end
            if (mode5 && addrA == 5'd2 && rdy) begin
               we = 1'b1; waddr = 5'd2; wdata = 32'h1234_5678;
            end
            if (poke && (addrA == 5'd4 || addrA == 5'd31)) startA = 1'b1;
            chk("send_raddr", {27'd0, raddrA}, beat);
            if (rdy) begin
               chk("beat_addr", {27'd0, addrA}, beat);
               chk("beat_data", dataA, exp_beat[beat[4:0]]);
               beat++;
            end
            prev_stall = !rdy;
            pa = addrA;
            pd = dataA;
         end else begin
            prev_stall = 1'b0;
            if (busyA && !doneA) chk("read_raddr", {27'd0, raddrA}, beat);
         end
         if (doneA) begin
            dones++;
            if (stall_pct == 0 && !mode5) chk("done_cycle", cyc, 64);
            chk("done_valid_low", {31'd0, validA}, 32'd0);
            if (poke) startA = 1'b1;
         end
         readyA = rdy;
         if (cyc > 0 && !busyA) break;
         if (cyc > 4000) begin
            tests++; fails++;
            $error("FAIL dump_timeout observed=%0d beats expected=32", beat);
            break;
         end
         step();
         cyc++;
         we = 1'b0;
         startA = 1'b0;
      end
      readyA = 1'b0;
      startA = 1'b0;
      chk("beat_count", beat, 32);
      chk("done_count", dones, 1);
      step();
      chk("idle_after_dump", {31'd0, busyA}, 32'd0);
   endtask

   initial begin
      int cyc, beat, dones;
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      startA = 1'b0; readyA = 1'b0; startB = 1'b0; readyB = 1'b0;
      step(); step();
      chk("rst_busy", {31'd0, busyA}, 32'd0);
      chk("rst_done", {31'd0, doneA}, 32'd0);
      chk("rst_valid", {31'd0, validA}, 32'd0);
      chk("rst_addr", {27'd0, addrA}, 32'd0);
      chk("rst_data", dataA, 32'd0);
      chk("rst_raddr", {27'd0, raddrA}, 32'd0);
      rst = 1'b0;

      for (int i = 1; i < 32; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = 32'h0101_0101 * i;
         step();
      end
      we = 1'b0;
      for (int i = 0; i < 32; i++) exp_beat[i] = 32'h0101_0101 * i;
      step();
      chk("idle_no_start", {31'd0, busyA}, 32'd0);

      // 1: full-speed dump; 2: random backpressure; 3: ignored start pokes
      do_dump(0, 1'b0, 1'b0);
      do_dump(30, 1'b0, 1'b0);
      do_dump(0, 1'b1, 1'b0);

      // 4: reset while beat 10 is valid
      startA = 1'b1; step(); startA = 1'b0; readyA = 1'b1;
      cyc = 0;
      while (!(validA && addrA == 5'd10) && cyc < 200) begin step(); cyc++; end
      chk("reach_beat10", {27'd0, addrA}, 32'd10);
      readyA = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      chk("abort_valid", {31'd0, validA}, 32'd0);
      chk("abort_busy", {31'd0, busyA}, 32'd0);
      chk("abort_done", {31'd0, doneA}, 32'd0);
      chk("abort_addr", {27'd0, addrA}, 32'd0);
      chk("abort_raddr", {27'd0, raddrA}, 32'd0);
      step();
      chk("abort_no_done", {31'd0, doneA}, 32'd0);
      do_dump(0, 1'b0, 1'b0);

      // 5: writes racing the dump
      exp_beat[5] = 32'hDEAD_BEEF;
      do_dump(0, 1'b0, 1'b1);
      exp_beat[2] = 32'h1234_5678;

      // 6: 16-register instance
      startB = 1'b1; step(); startB = 1'b0; readyB = 1'b1;
      cyc = 0; beat = 0; dones = 0;
      while (cyc < 200) begin
         chk("b_raddr_range", {31'd0, raddrB < 5'd16}, 32'd1);
         if (validB) begin
            chk("b_beat_addr", {27'd0, addrB}, beat);
            chk("b_beat_data", dataB, exp_beat[beat[4:0]]);
            beat++;
         end
         if (doneB) begin
            dones++;
            chk("b_done_cycle", cyc, 32);
         end
         if (cyc > 0 && !busyB) break;
         step();
         cyc++;
      end
      readyB = 1'b0;
      chk("b_beat_count", beat, 16);
      chk("b_done_count", dones, 1);
      chk("b_idle", {31'd0, busyB}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
